// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak/SHAKE front end.
// Domain-separation bytes, pad terminator, rate sizes and padder states.
package keccak_pkg;

    localparam logic [7:0] SHAKE_DS = 8'h1F;
    localparam logic [7:0] SHA3_DS  = 8'h06;
    localparam logic [7:0] PAD_END  = 8'h80;

    localparam int RATE_128 = 168;
    localparam int RATE_256 = 136;

    function automatic int rate_words(input int rate_b, input int wbytes);
        return rate_b / wbytes;
    endfunction

    // Word counts for the default 32-bit word width
    localparam int RW_128 = rate_words(RATE_128, 4);
    localparam int RW_256 = rate_words(RATE_256, 4);

    typedef enum logic [1:0] {
        S_MSG  = 2'd0,
        S_PAD  = 2'd1,
        S_FILL = 2'd2
    } pad_state_e;

endpackage

// File: rtl/shake_pad_word.sv
// Combinational builder of one padded output word.
// Keeps nbytes message bytes, drops the domain byte after them, ORs 0x80 on top.
module shake_pad_word
    import keccak_pkg::*;
#(
    parameter  int WIN    = 32,
    localparam int WBYTES = WIN / 8,
    localparam int NB_W   = $clog2(WBYTES + 1)
) (
    input  logic [WIN-1:0]  word_i,
    input  logic [NB_W-1:0] nbytes_i,
    input  logic            ds_en_i,
    input  logic            end_en_i,
    input  logic [7:0]      ds_i,
    output logic [WIN-1:0]  data_o
);

    // Per-byte select: message byte, domain byte or zero, then pad end
    always_comb begin
        data_o = '0;
        for (int i = 0; i < WBYTES; i++) begin
            if (!ds_en_i || (NB_W'(i) < nbytes_i)) begin
                data_o[8*i +: 8] = word_i[8*i +: 8];
            end else if (NB_W'(i) == nbytes_i) begin
                data_o[8*i +: 8] = ds_i;
            end
        end
        if (end_en_i) begin
            data_o[WIN-1 -: 8] = data_o[WIN-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/shake_msg_padder.sv
// SHAKE message padder: aligns a message stream to rate blocks with pad10*1.
// Optional SHAKE_PADDER_SHA3_EN adds sha3_sel to select the SHA3 domain byte.
module shake_msg_padder
    import keccak_pkg::*;
#(
    parameter  int WIN    = 32,
    parameter  int CNT_W  = 6,
    localparam int WBYTES = WIN / 8,
    localparam int NB_W   = $clog2(WBYTES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mux256,
`ifdef SHAKE_PADDER_SHA3_EN
    input  logic            sha3_sel,
`endif
    input  logic [WIN-1:0]  in_data,
    input  logic [NB_W-1:0] in_bytes,
    input  logic            in_last,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [WIN-1:0]  out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bof,
    output logic            out_eob,
    output logic            out_last
);

    localparam logic [CNT_W-1:0] LAST_128 =
        CNT_W'(rate_words(RATE_128, WBYTES) - 1);
    localparam logic [CNT_W-1:0] LAST_256 =
        CNT_W'(rate_words(RATE_256, WBYTES) - 1);

    pad_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             m256_q, m256_d;
    logic [WIN-1:0]   data_q, data_d;
    logic             valid_q, valid_d;
    logic             bof_q, bof_d;
    logic             eob_q, eob_d;
    logic             last_q, last_d;

    logic             m_sel;
    logic             at_end;
    logic             can_ld;
    logic             ld;
    logic             full_w;
    logic [WIN-1:0]   word_sel;
    logic [NB_W-1:0]  nb_sel;
    logic             ds_en;
    logic             end_en;
    logic [7:0]       ds_byte;
    logic [WIN-1:0]   pad_data;

`ifdef SHAKE_PADDER_SHA3_EN
    logic             sha3_q, sha3_d;
    logic             sha3_cur;

    assign sha3_cur = first_q ? sha3_sel : sha3_q;
    assign ds_byte  = sha3_cur ? SHA3_DS : SHAKE_DS;
    assign sha3_d   = (ld && first_q) ? sha3_sel : sha3_q;

    // Hash-mode latch, captured with the first word of a message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha3_q <= 1'b0;
        end else begin
            sha3_q <= sha3_d;
        end
    end
`else
    assign ds_byte = SHAKE_DS;
`endif

    // Rate mode comes live from the port only on a message's first word
    assign m_sel    = first_q ? mux256 : m256_q;
    assign at_end   = (cnt_q == (m_sel ? LAST_256 : LAST_128));
    assign can_ld   = ~valid_q | out_ready;
    assign in_ready = (state_q == S_MSG) & can_ld;
    assign full_w   = (in_bytes == NB_W'(WBYTES));
    assign ld       = can_ld & ((state_q != S_MSG) | in_valid);

    // Word-builder controls for the word about to be loaded
    always_comb begin
        word_sel = '0;
        nb_sel   = '0;
        ds_en    = 1'b0;
        end_en   = 1'b0;
        unique case (state_q)
            S_MSG: begin
                word_sel = in_data;
                nb_sel   = in_bytes;
                ds_en    = in_last & ~full_w;
                end_en   = in_last & ~full_w & at_end;
            end
            S_PAD: begin
                ds_en  = 1'b1;
                end_en = at_end;
            end
            S_FILL: begin
                end_en = at_end;
            end
            default: ;
        endcase
    end

    shake_pad_word #(
        .WIN (WIN)
    ) u_pad_word (
        .word_i   (word_sel),
        .nbytes_i (nb_sel),
        .ds_en_i  (ds_en),
        .end_en_i (end_en),
        .ds_i     (ds_byte),
        .data_o   (pad_data)
    );

    // Next state, counter, flags and output register load
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        m256_d  = m256_q;
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        bof_d   = bof_q;
        eob_d   = eob_q;
        last_d  = last_q;
        if (ld) begin
            valid_d = 1'b1;
            data_d  = pad_data;
            bof_d   = first_q;
            eob_d   = at_end;
            last_d  = 1'b0;
            first_d = 1'b0;
            cnt_d   = at_end ? '0 : cnt_q + 1'b1;
            if (first_q) begin
                m256_d = mux256;
            end
            unique case (state_q)
                S_MSG: begin
                    if (in_last) begin
                        if (full_w) begin
                            state_d = S_PAD;
                        end else if (at_end) begin
                            last_d  = 1'b1;
                            first_d = 1'b1;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_PAD, S_FILL: begin
                    if (at_end) begin
                        last_d  = 1'b1;
                        first_d = 1'b1;
                        state_d = S_MSG;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                default: state_d = S_MSG;
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MSG;
            cnt_q   <= '0;
            first_q <= 1'b1;
            m256_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            bof_q   <= 1'b0;
            eob_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            m256_q  <= m256_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            bof_q   <= bof_d;
            eob_q   <= eob_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_bof   = bof_q;
    assign out_eob   = eob_q;
    assign out_last  = last_q;

endmodule
